// File: rtl/input_port_vc.sv
// input_port_vc: router input port with per-VC flit FIFOs, XY routing and a
// request/grant handshake toward the L/R/U/D/PE output arbiters.
//
// Ports
//   clk       clock, all state on posedge
//   rst       asynchronous active-low reset
//   si        upstream send strobe (datai valid)
//   datai     flit: VC index in the MSBs, then dst_x, then dst_y
//   ri        per-VC ready, high while that VC FIFO is not full
//   gnt       one-hot grant {L,R,U,D,PE}
//   reqL..PE  one-hot request for the head flit of the selected VC
//   datao     head flit of the selected VC
//   vco       VC index of datao
//   err       sticky, set on the first dropped (U-turn) flit
//   drop_cnt  dropped-flit count, saturating at 255
module input_port_vc #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned NUM_VC       = 2,
  parameter int unsigned BUFFER_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned CUR_X        = 0,
  parameter int unsigned CUR_Y        = 0,
  parameter logic [4:0]  DIRECTION    = 5'b00001
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        si,
  input  logic [DATA_WIDTH-1:0]       datai,
  output logic [NUM_VC-1:0]           ri,
  input  logic [4:0]                  gnt,
  output logic                        reqL,
  output logic                        reqR,
  output logic                        reqU,
  output logic                        reqD,
  output logic                        reqPE,
  output logic [DATA_WIDTH-1:0]       datao,
  output logic [$clog2(NUM_VC)-1:0]   vco,
  output logic                        err,
  output logic [7:0]                  drop_cnt
);

  localparam int unsigned VC_BITS  = $clog2(NUM_VC);
  localparam int unsigned PTR_BITS = $clog2(BUFFER_DEPTH);
  localparam int unsigned CNT_BITS = $clog2(BUFFER_DEPTH + 1);

  localparam logic [ADDR_WIDTH-1:0] CX     = ADDR_WIDTH'(CUR_X);
  localparam logic [ADDR_WIDTH-1:0] CY     = ADDR_WIDTH'(CUR_Y);
  localparam logic [CNT_BITS-1:0]   FULL   = CNT_BITS'(BUFFER_DEPTH);
  localparam logic [4:0]            DIR_L  = 5'b10000;
  localparam logic [4:0]            DIR_R  = 5'b01000;
  localparam logic [4:0]            DIR_U  = 5'b00100;
  localparam logic [4:0]            DIR_D  = 5'b00010;
  localparam logic [4:0]            DIR_PE = 5'b00001;

  typedef enum logic {IDLE, REQ} state_e;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem_q [NUM_VC][BUFFER_DEPTH];
  logic [PTR_BITS-1:0]   rd_ptr_q [NUM_VC];
  logic [PTR_BITS-1:0]   rd_ptr_d [NUM_VC];
  logic [PTR_BITS-1:0]   wr_ptr_q [NUM_VC];
  logic [PTR_BITS-1:0]   wr_ptr_d [NUM_VC];
  logic [CNT_BITS-1:0]   count_q  [NUM_VC];
  logic [CNT_BITS-1:0]   count_d  [NUM_VC];
  logic [CNT_BITS-1:0]   cnt_after_pop [NUM_VC];
  logic [DATA_WIDTH-1:0] head_nxt [NUM_VC];
  logic [NUM_VC-1:0]     nonempty_now;
  logic [NUM_VC-1:0]     nonempty_nxt;

  // Selection / FSM state
  state_e                state_q;
  logic [VC_BITS-1:0]    sel_vc_q;
  logic [VC_BITS-1:0]    rr_ptr_q;
  logic [VC_BITS-1:0]    rr_ptr_d;
  logic [4:0]            req_q;
  logic                  illegal_q;
  logic [DATA_WIDTH-1:0] datao_q;
  logic [VC_BITS-1:0]    vco_q;
  logic                  err_q;
  logic [7:0]            drop_q;

  // Combinational control
  logic                  push;
  logic                  pop;
  logic                  load;
  logic [VC_BITS-1:0]    push_vc;
  logic [NUM_VC-1:0]     cand;
  logic [VC_BITS-1:0]    search_base;
  logic [VC_BITS-1:0]    idx;
  logic [VC_BITS-1:0]    pick;
  logic [DATA_WIDTH-1:0] load_flit;
  logic [ADDR_WIDTH-1:0] load_dx;
  logic [ADDR_WIDTH-1:0] load_dy;
  logic [4:0]            load_route;
  logic                  load_illegal;

  function automatic logic [4:0] route_of(input logic [ADDR_WIDTH-1:0] dx,
                                          input logic [ADDR_WIDTH-1:0] dy);
    if (dx > CX)      route_of = DIR_R;
    else if (dx < CX) route_of = DIR_L;
    else if (dy > CY) route_of = DIR_U;
    else if (dy < CY) route_of = DIR_D;
    else              route_of = DIR_PE;
  endfunction

  always_comb begin
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      ri[v] = (count_q[v] != FULL);
    end
  end

  // Next-cycle FIFO view. The next selection is made from this view so the
  // registered request/datao can be loaded in the same edge as a pop, which
  // gives back-to-back service. A flit pushed into a VC that is empty after
  // the pop is forwarded straight from datai as that VC's next head.
  always_comb begin
    push_vc = datai[DATA_WIDTH-1 -: VC_BITS];
    push    = si && ri[push_vc];
    pop     = (state_q == REQ) && (illegal_q || (gnt == req_q));
    rr_ptr_d = pop ? (sel_vc_q + VC_BITS'(1)) : rr_ptr_q;

    for (int unsigned v = 0; v < NUM_VC; v++) begin
      cnt_after_pop[v] = count_q[v] - CNT_BITS'(pop && (sel_vc_q == VC_BITS'(v)));
      rd_ptr_d[v]      = rd_ptr_q[v] + PTR_BITS'(pop && (sel_vc_q == VC_BITS'(v)));
      wr_ptr_d[v]      = wr_ptr_q[v] + PTR_BITS'(push && (push_vc == VC_BITS'(v)));
      count_d[v]       = cnt_after_pop[v] + CNT_BITS'(push && (push_vc == VC_BITS'(v)));
      head_nxt[v]      = (push && (push_vc == VC_BITS'(v)) && (cnt_after_pop[v] == '0))
                         ? datai : mem_q[v][rd_ptr_d[v]];
      nonempty_now[v]  = (count_q[v] != '0);
      nonempty_nxt[v]  = (count_d[v] != '0);
    end

    // IDLE looks only at what was buffered before this edge; a pop in REQ
    // looks at the state after this edge's pop and push.
    cand        = (state_q == IDLE) ? nonempty_now : nonempty_nxt;
    search_base = (state_q == IDLE) ? rr_ptr_q : rr_ptr_d;
    load        = ((state_q == IDLE) || pop) && (|cand);

    // Scan downward so the closest non-empty VC to search_base wins.
    pick = search_base;
    idx  = search_base;
    for (int unsigned i = NUM_VC; i > 0; i--) begin
      idx = search_base + VC_BITS'(i - 1);
      if (cand[idx]) pick = idx;
    end

    load_flit    = head_nxt[pick];
    load_dx      = load_flit[DATA_WIDTH-1-VC_BITS -: ADDR_WIDTH];
    load_dy      = load_flit[DATA_WIDTH-1-VC_BITS-ADDR_WIDTH -: ADDR_WIDTH];
    load_route   = route_of(load_dx, load_dy);
    load_illegal = (load_route == DIRECTION) && (DIRECTION != DIR_PE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        rd_ptr_q[v] <= '0;
        wr_ptr_q[v] <= '0;
        count_q[v]  <= '0;
      end
    end else begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        rd_ptr_q[v] <= rd_ptr_d[v];
        wr_ptr_q[v] <= wr_ptr_d[v];
        count_q[v]  <= count_d[v];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[push_vc][wr_ptr_q[push_vc]] <= datai;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sel_vc_q  <= '0;
      rr_ptr_q  <= '0;
      req_q     <= '0;
      illegal_q <= 1'b0;
      datao_q   <= '0;
      vco_q     <= '0;
      err_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (pop && illegal_q) begin
        err_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
      if (load) begin
        state_q   <= REQ;
        sel_vc_q  <= pick;
        vco_q     <= pick;
        datao_q   <= load_flit;
        illegal_q <= load_illegal;
        req_q     <= load_illegal ? '0 : load_route;
      end else if (pop) begin
        state_q   <= IDLE;
        req_q     <= '0;
        illegal_q <= 1'b0;
      end
    end
  end

  assign reqL     = req_q[4];
  assign reqR     = req_q[3];
  assign reqU     = req_q[2];
  assign reqD     = req_q[1];
  assign reqPE    = req_q[0];
  assign datao    = datao_q;
  assign vco      = vco_q;
  assign err      = err_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_input_port_vc.sv
// Testbench for input_port_vc (NUM_VC=2, depth 4, router at (1,1), port faces L).
// Table-driven vectors, directed multi-cycle sequences, and a randomized run
// checked against a queue-based reference model.
module tb_input_port_vc;

  logic        clk = 1'b0;
  logic        rst;
  logic        si;
  logic [63:0] datai;
  logic [1:0]  ri;
  logic [4:0]  gnt;
  logic        reqL, reqR, reqU, reqD, reqPE;
  logic [63:0] datao;
  logic [0:0]  vco;
  logic        err;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  input_port_vc #(
    .DATA_WIDTH  (64),
    .NUM_VC      (2),
    .BUFFER_DEPTH(4),
    .ADDR_WIDTH  (4),
    .CUR_X       (1),
    .CUR_Y       (1),
    .DIRECTION   (5'b10000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .si      (si),
    .datai   (datai),
    .ri      (ri),
    .gnt     (gnt),
    .reqL    (reqL),
    .reqR    (reqR),
    .reqU    (reqU),
    .reqD    (reqD),
    .reqPE   (reqPE),
    .datao   (datao),
    .vco     (vco),
    .err     (err),
    .drop_cnt(drop_cnt)
  );

  int n_err = 0;
  int n_chk = 0;

  // Reference model: one queue per VC plus the currently offered VC.
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  bit          m_active;
  int          m_sel;
  int          m_rr;
  int          m_drop;
  bit          m_err;

  typedef struct {
    bit          si;
    logic [63:0] d;
    logic [4:0]  g;
    logic [4:0]  req;
    logic [1:0]  ri;
    bit          err;
    logic [7:0]  drop;
    logic [63:0] data;
    bit          vco;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] mk(int vc, int x, int y, logic [54:0] pl);
    logic [63:0] f;
    f = {vc[0], x[3:0], y[3:0], pl};
    return f;
  endfunction

  function automatic logic [4:0] route(logic [63:0] f);
    logic [3:0] x, y;
    x = f[62:59];
    y = f[58:55];
    if (x > 4'd1) return 5'b01000;
    if (x < 4'd1) return 5'b10000;
    if (y > 4'd1) return 5'b00100;
    if (y < 4'd1) return 5'b00010;
    return 5'b00001;
  endfunction

  function automatic bit illegal(logic [63:0] f);
    return route(f) == 5'b10000;
  endfunction

  function automatic logic [63:0] qfront(int v);
    if (v == 0) return (q0.size() > 0) ? q0[0] : 64'd0;
    return (q1.size() > 0) ? q1[0] : 64'd0;
  endfunction

  function automatic int pick_from(int rr, int s0, int s1);
    for (int i = 0; i < 2; i++) begin
      int v;
      v = (rr + i) % 2;
      if ((v == 0 && s0 > 0) || (v == 1 && s1 > 0)) return v;
    end
    return rr;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_active = 1'b0;
    m_sel    = 0;
    m_rr     = 0;
    m_drop   = 0;
    m_err    = 1'b0;
  endtask

  task automatic model_step(bit s, logic [63:0] d, logic [4:0] g);
    int          s0;
    int          s1;
    int          vcp;
    bit          was;
    bit          pop;
    logic [63:0] cur;
    s0  = q0.size();
    s1  = q1.size();
    vcp = int'(d[63]);
    was = m_active;
    pop = 1'b0;
    cur = '0;
    if (was) begin
      cur = qfront(m_sel);
      pop = illegal(cur) || (g == route(cur));
    end
    if (pop) begin
      if (illegal(cur)) begin
        m_err = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      if (m_sel == 0) void'(q0.pop_front());
      else            void'(q1.pop_front());
      m_rr = (m_sel + 1) % 2;
    end
    if (s && vcp == 0 && s0 < 4) q0.push_back(d);
    if (s && vcp == 1 && s1 < 4) q1.push_back(d);
    if (!was) begin
      if (s0 > 0 || s1 > 0) begin
        m_sel    = pick_from(m_rr, s0, s1);
        m_active = 1'b1;
      end
    end else if (pop) begin
      if (q0.size() > 0 || q1.size() > 0) m_sel = pick_from(m_rr, q0.size(), q1.size());
      else m_active = 1'b0;
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    logic [4:0]  er;
    logic [63:0] f;
    er = '0;
    if (m_active) begin
      f = qfront(m_sel);
      if (!illegal(f)) er = route(f);
    end
    chk($sformatf("%s req", tag), 64'({reqL, reqR, reqU, reqD, reqPE}), 64'(er));
    chk($sformatf("%s ri", tag), 64'(ri), 64'({q1.size() < 4, q0.size() < 4}));
    chk($sformatf("%s err", tag), 64'(err), 64'(m_err));
    chk($sformatf("%s drop", tag), 64'(drop_cnt), 64'(m_drop));
    if (er != 5'b0) begin
      chk($sformatf("%s datao", tag), datao, qfront(m_sel));
      chk($sformatf("%s vco", tag), 64'(vco), 64'(m_sel));
    end
  endtask

  // Called just after a negedge: drive, advance one edge, check at next negedge.
  task automatic cycle(bit s, logic [63:0] d, logic [4:0] g, string tag);
    si    = s;
    datai = d;
    gnt   = g;
    @(posedge clk);
    model_step(s, d, g);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset();
    si    = 1'b0;
    gnt   = '0;
    datai = '0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    check_model("reset");
  endtask

  initial begin
    logic [63:0] f1, fb, f2, fl;
    rst   = 1'b0;
    si    = 1'b0;
    gnt   = '0;
    datai = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Basic service and U-turn drop, as a vector table.
    f1 = mk(0, 2, 1, 55'h11);
    fb = mk(0, 0, 1, 55'h22);
    f2 = mk(1, 1, 0, 55'h33);
    tbl.push_back('{1'b1, f1,    5'b00000, 5'b00000, 2'b11, 1'b0, 8'd0, 64'd0, 1'b0});
    tbl.push_back('{1'b0, 64'd0, 5'b00000, 5'b01000, 2'b11, 1'b0, 8'd0, f1,    1'b0});
    tbl.push_back('{1'b0, 64'd0, 5'b00000, 5'b01000, 2'b11, 1'b0, 8'd0, f1,    1'b0});
    tbl.push_back('{1'b0, 64'd0, 5'b01000, 5'b00000, 2'b11, 1'b0, 8'd0, 64'd0, 1'b0});
    tbl.push_back('{1'b0, 64'd0, 5'b01000, 5'b00000, 2'b11, 1'b0, 8'd0, 64'd0, 1'b0});
    tbl.push_back('{1'b1, fb,    5'b00000, 5'b00000, 2'b11, 1'b0, 8'd0, 64'd0, 1'b0});
    tbl.push_back('{1'b0, 64'd0, 5'b10000, 5'b00000, 2'b11, 1'b0, 8'd0, 64'd0, 1'b0});
    tbl.push_back('{1'b1, f2,    5'b00000, 5'b00010, 2'b11, 1'b1, 8'd1, f2,    1'b1});
    tbl.push_back('{1'b0, 64'd0, 5'b00010, 5'b00000, 2'b11, 1'b1, 8'd1, 64'd0, 1'b0});
    tbl.push_back('{1'b0, 64'd0, 5'b00000, 5'b00000, 2'b11, 1'b1, 8'd1, 64'd0, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      si    = tbl[i].si;
      datai = tbl[i].d;
      gnt   = tbl[i].g;
      @(posedge clk);
      model_step(tbl[i].si, tbl[i].d, tbl[i].g);
      @(negedge clk);
      chk($sformatf("tbl%0d req", i), 64'({reqL, reqR, reqU, reqD, reqPE}), 64'(tbl[i].req));
      chk($sformatf("tbl%0d ri", i), 64'(ri), 64'(tbl[i].ri));
      chk($sformatf("tbl%0d err", i), 64'(err), 64'(tbl[i].err));
      chk($sformatf("tbl%0d drop", i), 64'(drop_cnt), 64'(tbl[i].drop));
      if (tbl[i].req != 5'b0) begin
        chk($sformatf("tbl%0d datao", i), datao, tbl[i].data);
        chk($sformatf("tbl%0d vco", i), 64'(vco), 64'(tbl[i].vco));
      end
    end

    // Fill VC1, overflow attempt, then drain in order.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, mk(1, 1, 1, 55'(100 + i)), 5'b00000, "fill");
      if (i == 3) chk("fill ri full", 64'(ri), 64'(2'b01));
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain order %0d", i), datao, mk(1, 1, 1, 55'(100 + i)));
      cycle(1'b0, 64'd0, 5'b00001, "drain");
    end
    chk("drain idle req", 64'(reqPE), 64'd0);
    chk("drain ri", 64'(ri), 64'(2'b11));

    // Round robin between VCs with grant held.
    do_reset();
    cycle(1'b1, mk(0, 1, 1, 55'h30), 5'b00001, "rr push0");
    cycle(1'b1, mk(1, 1, 1, 55'h31), 5'b00001, "rr push1");
    chk("rr first vco", 64'(vco), 64'd0);
    chk("rr first req", 64'(reqPE), 64'd1);
    cycle(1'b0, 64'd0, 5'b00001, "rr grant0");
    chk("rr second vco", 64'(vco), 64'd1);
    chk("rr second data", datao, mk(1, 1, 1, 55'h31));
    cycle(1'b0, 64'd0, 5'b00001, "rr grant1");
    chk("rr idle req", 64'(reqPE), 64'd0);

    // Wrong grants are ignored.
    do_reset();
    fl = mk(1, 1, 2, 55'h55);
    cycle(1'b1, fl, 5'b00000, "wg push");
    cycle(1'b0, 64'd0, 5'b00000, "wg wait");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 64'd0, 5'b10000, "wg wrong");
      chk("wg hold reqU", 64'(reqU), 64'd1);
      chk("wg hold data", datao, fl);
    end
    cycle(1'b0, 64'd0, 5'b00100, "wg right");
    chk("wg popped", 64'(reqU), 64'd0);

    // Asynchronous reset while requesting.
    do_reset();
    cycle(1'b1, mk(0, 1, 1, 55'h61), 5'b00000, "rst push");
    cycle(1'b1, mk(0, 1, 1, 55'h62), 5'b00000, "rst push");
    cycle(1'b1, mk(1, 1, 1, 55'h63), 5'b00000, "rst push");
    si = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async rst req", 64'({reqL, reqR, reqU, reqD, reqPE}), 64'd0);
    chk("async rst datao", datao, 64'd0);
    chk("async rst vco", 64'(vco), 64'd0);
    chk("async rst ri", 64'(ri), 64'(2'b11));
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 5'b00001, "post rst");

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit          s;
      logic [63:0] d;
      logic [4:0]  g;
      logic [63:0] h;
      int          r;
      s = 1'($urandom_range(0, 1));
      d = mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), 55'($urandom));
      h = qfront(m_sel);
      if (m_active && !illegal(h) && $urandom_range(0, 9) < 6) begin
        g = route(h);
      end else begin
        r = int'($urandom_range(0, 5));
        g = (r == 0) ? 5'b00000 : 5'(1 << (r - 1));
      end
      cycle(s, d, g, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
